// File: rtl/move_sched.sv
// Frame-tick driven scheduler sharing one movement engine between two characters.
// Each tick latches the active mask; pending characters are served round-robin.
//
// state | meaning
// IDLE  | nothing pending, waiting for a frame tick to set pend bits
// ISSUE | one-cycle start pulse for the round-robin selected character
// WAIT  | engine busy; leave on eng_done or when the timeout window expires
module move_sched #(
    parameter int TICK_DIV = 1000000,
    parameter int TIMEOUT  = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [1:0] req_en,
    input  logic       eng_done,
    input  logic       clr_err,
    output logic       frame_tick,
    output logic       eng_start,
    output logic       eng_sel,
    output logic       busy,
    output logic       overrun,
    output logic       timeout_err
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [TW-1:0]   tick_cnt;
    logic [WW-1:0]   wait_cnt;
    logic [1:0]      pend;
    logic [1:0]      clr_mask;
    logic            last;
    logic            pick;
    logic            wait_exit;
    logic            wait_expired;
    logic            overrun_set;

    assign frame_tick   = en && (tick_cnt == TICK_LAST);
    assign pick         = pend[~last] ? ~last : last;
    assign clr_mask     = (state == ISSUE) ? {pick, ~pick} : 2'b00;
    assign wait_exit    = (state == WAIT) && (eng_done || (wait_cnt == WAIT_LAST));
    assign wait_expired = (state == WAIT) && !eng_done && (wait_cnt == WAIT_LAST);
    assign overrun_set  = frame_tick && ((state != IDLE) || (pend != 2'b00));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt <= '0;
        end else if (!en || (tick_cnt == TICK_LAST)) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + TW'(1);
        end
    end

    // A tick setting a bit wins over the ISSUE clearing the same bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend     <= 2'b00;
            last     <= 1'b1;
            wait_cnt <= '0;
        end else begin
            pend <= (pend & ~clr_mask) | (frame_tick ? req_en : 2'b00);
            if (state == ISSUE) begin
                last     <= pick;
                wait_cnt <= '0;
            end else if ((state == WAIT) && (wait_cnt != WAIT_LAST)) begin
                wait_cnt <= wait_cnt + WW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun     <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            if (overrun_set) begin
                overrun <= 1'b1;
            end else if (clr_err) begin
                overrun <= 1'b0;
            end
            if (wait_expired) begin
                timeout_err <= 1'b1;
            end else if (clr_err) begin
                timeout_err <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (pend != 2'b00) state_nxt = ISSUE;
            ISSUE:   state_nxt = WAIT;
            WAIT:    if (wait_exit) state_nxt = (pend != 2'b00) ? ISSUE : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        eng_start = 1'b0;
        eng_sel   = 1'b0;
        busy      = (state != IDLE);
        case (state)
            ISSUE: begin
                eng_start = 1'b1;
                eng_sel   = pick;
            end
            WAIT:    eng_sel = last;
            default: eng_sel = 1'b0;
        endcase
    end

endmodule

// File: doc/move_sched.md
MOVE_SCHED -- requirements
Module: move_sched

Interface
REQ-001 The block SHALL have parameter TICK_DIV, default 1000000, meaning clk cycles per game frame tick (50 Hz at 50 MHz).
REQ-002 The block SHALL have parameter TIMEOUT, default 255, meaning the maximum number of WAIT cycles allowed for an engine update.
REQ-003 Port clk  input  1  is the single system clock; all state changes on its rising edge.
REQ-004 Port rst_n  input  1  is the asynchronous, active-low reset.
REQ-005 Port en  input  1  is the frame tick generator enable.
REQ-006 Port req_en  input  2  gives the per-character active mask; bit i=1 means character i is updated each frame.
REQ-007 Port eng_done  input  1  is the shared movement engine's update-complete pulse.
REQ-008 Port clr_err  input  1  clears the sticky error flags.
REQ-009 Port frame_tick  output  1  is a one-cycle frame strobe.
REQ-010 Port eng_start  output  1  is a one-cycle start pulse to the shared engine.
REQ-011 Port eng_sel  output  1  is the index of the character being updated; valid from eng_start until the WAIT state exits.
REQ-012 Port busy  output  1  is high whenever the FSM is not in IDLE.
REQ-013 Port overrun  output  1  is a sticky flag: a tick arrived while a frame was still being processed.
REQ-014 Port timeout_err  output  1  is a sticky flag: the engine did not deliver eng_done within TIMEOUT cycles.

Function
REQ-015 The tick counter SHALL count 0..TICK_DIV-1 while en=1, pulse frame_tick for the cycle in which it equals TICK_DIV-1, then wrap to 0.
REQ-016 While en=0, the tick counter SHALL be held at 0 and frame_tick SHALL stay 0.
REQ-017 On frame_tick, the 2-bit pending register SHALL update to pend | req_en, so no pending request is lost.
REQ-018 If frame_tick occurs while state!=IDLE or pend!=0 (before the OR), overrun SHALL be set on the next edge.
REQ-019 The FSM SHALL have three states: IDLE, ISSUE and WAIT.
REQ-020 IDLE: if pend!=0, the FSM SHALL move to ISSUE on the next edge; otherwise it SHALL remain in IDLE.
REQ-021 ISSUE (exactly one cycle):
- select the pending index with round-robin priority starting at last+1 (mod 2);
- drive eng_start=1 and set eng_sel to the selected index;
- clear that pend bit, update last to the selected index, clear the timeout counter;
- go to WAIT.
REQ-022 WAIT: on eng_done=1, the FSM SHALL go to ISSUE if any pend bit remains, otherwise to IDLE.
REQ-023 WAIT: if the timeout counter reaches TIMEOUT without eng_done, the FSM SHALL set timeout_err and take the same transition as REQ-022 (the update is abandoned).
REQ-024 eng_done SHALL be ignored outside WAIT, including in the ISSUE cycle.
REQ-025 eng_start SHALL never be asserted in two consecutive cycles; minimum spacing is ISSUE, WAIT, ISSUE (2 cycles).
REQ-026 If a frame_tick OR and an ISSUE clear hit the same pend bit in the same cycle, the set SHALL win.
REQ-027 If en falls mid-frame, the current update SHALL complete and the remaining pend bits SHALL still be served; only new ticks stop.
REQ-028 Changes to req_en between ticks SHALL have no effect until the next frame_tick.
REQ-029 clr_err=1 SHALL clear overrun and timeout_err on the next edge; a new error event in the same cycle SHALL win (flag stays 1).
REQ-030 Counters SHALL be sized with $clog2 of their parameter; no arithmetic overflow is permitted for TICK_DIV≥2 and TIMEOUT≥1.

Reset
REQ-031 On rst_n=0, asynchronously:
- state=IDLE, pend=0, last=1 (so character 0 is served first), tick and timeout counters=0;
- all outputs 0.
REQ-032 Reset asserted mid-WAIT SHALL abandon the update with no eng_start after release until the next frame_tick plus pend.

Verification (TICK_DIV=10, TIMEOUT=5)
REQ-033 Basic tick: en=1 from reset release -> frame_tick pulses on cycles 10, 20, 30 after release, each 1 cycle wide; en=0 -> no pulses and the counter reads 0.
REQ-034 Two characters, req_en=2'b11, engine returns done 3 cycles after start -> eng_start with eng_sel=0, then eng_sel=1, then IDLE with busy=0; next frame starts again with 0 first.
REQ-035 Round-robin: req_en=2'b01 for frame 1, then 2'b11 -> frame 1 serves 0; frame 2 serves 1 then 0.
REQ-036 Timeout: eng_done held 0 -> timeout_err=1 exactly TIMEOUT cycles after entering WAIT, the FSM proceeds to the next pending index, and clr_err clears the flag.
REQ-037 Overrun: engine delay 12 cycles with req_en=2'b11 -> overrun=1 after the second tick, and both characters are still served in the following frame.
REQ-038 Edge cases:
- eng_done pulsed in the ISSUE cycle is ignored;
- asserting rst_n=0 during WAIT yields all outputs 0 immediately.
